uart_rx_fifo: RTL and testbench

UART receiver with a small receive FIFO. It sits beside the existing `uart_tx` on the `uart_rxd` pin and gives the CPU memory-map glue a byte stream: first-word-fall-through data, a valid flag, and sticky error flags. It runs in the CPU clock domain and oversamples the asynchronous RX line once per `clk`, sampling each bit at its mid-point.

---
 rtl/uart_rx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (mid-bit sampled, 8N1) feeding a small first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky rx_parity_err output.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BIT_RATE   = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rxd,
    input  logic                          rx_pop,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_overrun,
    output logic                          rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                          rx_parity_err,
`endif
    input  logic                          clear_errors
);

    localparam int CPB  = CLK_HZ / BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB) + 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    // Timer counts down to zero; the zero cycle is the sample point.
    localparam logic [TW-1:0] LOAD_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] LOAD_BIT  = TW'(CPB - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    logic          sync1;
    logic          sync2;
    logic          rxs;
    logic          rxs_d;
    logic [1:0]    settle;
    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          push;
    logic          frame_set;
    logic          par_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovr_set;

    assign rxs  = sync2;
    assign tick = (timer == '0);

    // rxs_d only carries a 1 once real line samples have cleared the synchronizer,
    // so a line held low through reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            settle <= 2'b00;
            rxs_d  <= 1'b0;
        end else begin
            sync1  <= uart_rxd;
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
            rxs_d  <= rxs & settle[1];
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_set;
    assign parity_set = (state == PARITY) && tick && ((^shreg) ^ rxs);
`else
    assign par_bad = 1'b0;
`endif

    assign push      = (state == STOP) && tick && rxs && !par_bad;
    assign frame_set = (state == STOP) && tick && !rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            if (!tick)
                timer <= timer - TW'(1);

            case (state)
                IDLE: begin
                    if (rxs_d && !rxs) begin
                        timer <= LOAD_HALF;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            timer   <= LOAD_BIT;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {rxs, shreg[7:1]};
                        timer   <= LOAD_BIT;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad <= (^shreg) ^ rxs;
                        timer   <= LOAD_BIT;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick)
                        state <= rxs ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (frame_set)
                rx_frame_err <= 1'b1;
            else if (clear_errors)
                rx_frame_err <= 1'b0;

`ifdef UART_RX_PARITY_EN
            if (parity_set)
                rx_parity_err <= 1'b1;
            else if (clear_errors)
                rx_parity_err <= 1'b0;
`endif
        end
    end

    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = rx_pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (do_pop)
                rptr <= rptr + PW'(1);
            if (do_push)
                wptr <= wptr + PW'(1);

            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (clear_errors)
                rx_overrun <= 1'b0;
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = rx_valid ? mem[rptr] : 8'h00;
    assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (104 clocks per bit).
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx_fifo;

    localparam int CPB  = 104;
    localparam int HALF = 52;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Edges from driving the start bit low to the stop-sample edge.
    localparam int STOP_OFF = 3 + HALF + NB * CPB;

    logic       clk;
    logic       reset;
    logic       uart_rxd;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       clear_errors;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rx_pop       (rx_pop),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_count     (rx_count),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .clear_errors (clear_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int stop_low, input logic bad_par);
        uart_rxd = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_cycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = (^d) ^ bad_par;
        wait_cycles(CPB);
`endif
        if (stop_low > 0) begin
            uart_rxd = 1'b0;
            wait_cycles(stop_low * CPB);
        end
        uart_rxd = 1'b1;
        wait_cycles(CPB);
    endtask

    task automatic pop_head(input string name, input logic [7:0] exp);
        chk(name, 32'(rx_data), 32'(exp));
        rx_pop = 1'b1;
        wait_cycles(1);
        rx_pop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        wait_cycles(1);
        clear_errors = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{data: 8'h00, stop_low: 0, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hFF, stop_low: 0, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'h5A, stop_low: 0, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h80, stop_low: 0, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hC3, stop_low: 1, exp_valid: 1'b0, exp_ferr: 1'b1};

        uart_rxd     = 1'b1;
        reset        = 1'b1;
        rx_pop       = 1'b0;
        clear_errors = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(4);

        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);
        chk("reset_count", 32'(rx_count), 32'd0);
        chk("reset_overrun", 32'(rx_overrun), 32'd0);
        chk("reset_ferr", 32'(rx_frame_err), 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("reset_perr", 32'(rx_parity_err), 32'd0);
`endif

        // Single byte with exact push latency.
        fork
            send_byte(8'h55, 0, 1'b0);
            begin
                wait_cycles(STOP_OFF - 1);
                chk("x55_before_push", 32'(rx_valid), 32'd0);
                wait_cycles(1);
                chk("x55_valid", 32'(rx_valid), 32'd1);
                chk("x55_data", 32'(rx_data), 32'h55);
                chk("x55_count", 32'(rx_count), 32'd1);
            end
        join
        rx_pop = 1'b1;
        wait_cycles(1);
        rx_pop = 1'b0;
        chk("x55_pop_valid", 32'(rx_valid), 32'd0);
        chk("x55_pop_data", 32'(rx_data), 32'd0);
        rx_pop = 1'b1;
        wait_cycles(1);
        rx_pop = 1'b0;
        chk("pop_empty_count", 32'(rx_count), 32'd0);

        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].data, vecs[v].stop_low, 1'b0);
            chk($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_data", v), 32'(rx_data),
                vecs[v].exp_valid ? 32'(vecs[v].data) : 32'd0);
            chk($sformatf("vec%0d_ferr", v), 32'(rx_frame_err), 32'(vecs[v].exp_ferr));
            if (vecs[v].exp_valid) begin
                rx_pop = 1'b1;
                wait_cycles(1);
                rx_pop = 1'b0;
            end
            pulse_clear();
            chk($sformatf("vec%0d_cleared_ferr", v), 32'(rx_frame_err), 32'd0);
            chk($sformatf("vec%0d_count", v), 32'(rx_count), 32'd0);
        end

        // Overrun: five back-to-back bytes into a four-entry FIFO.
        for (int b = 1; b <= 5; b++)
            send_byte(8'(b), 0, 1'b0);
        chk("ovr_count", 32'(rx_count), 32'd4);
        chk("ovr_flag", 32'(rx_overrun), 32'd1);
        for (int b = 1; b <= 4; b++)
            pop_head($sformatf("ovr_pop%0d", b), 8'(b));
        chk("ovr_empty", 32'(rx_valid), 32'd0);
        chk("ovr_sticky", 32'(rx_overrun), 32'd1);
        pulse_clear();
        chk("ovr_cleared", 32'(rx_overrun), 32'd0);

        // Break-like stop bit, then a clean byte.
        send_byte(8'hA3, 2, 1'b0);
        chk("brk_ferr", 32'(rx_frame_err), 32'd1);
        chk("brk_nopush", 32'(rx_count), 32'd0);
        send_byte(8'h3C, 0, 1'b0);
        chk("after_brk_count", 32'(rx_count), 32'd1);
        pop_head("after_brk_data", 8'h3C);
        pulse_clear();
        chk("brk_cleared", 32'(rx_frame_err), 32'd0);

        // 20-cycle glitch; the FSM must be idle in time for a start 53 cycles later.
        uart_rxd = 1'b0;
        wait_cycles(20);
        uart_rxd = 1'b1;
        wait_cycles(33);
        chk("glitch_nopush", 32'(rx_valid), 32'd0);
        chk("glitch_noferr", 32'(rx_frame_err), 32'd0);
        send_byte(8'h96, 0, 1'b0);
        chk("glitch_next_count", 32'(rx_count), 32'd1);
        pop_head("glitch_next_data", 8'h96);

        // Full FIFO with a pop on the very stop-sample edge.
        for (int b = 0; b < 4; b++)
            send_byte(8'h11 + 8'(b), 0, 1'b0);
        chk("full_count", 32'(rx_count), 32'd4);
        fork
            send_byte(8'h15, 0, 1'b0);
            begin
                wait_cycles(STOP_OFF - 1);
                rx_pop = 1'b1;
                wait_cycles(1);
                rx_pop = 1'b0;
            end
        join
        chk("fullpop_count", 32'(rx_count), 32'd4);
        chk("fullpop_overrun", 32'(rx_overrun), 32'd0);
        for (int b = 0; b < 4; b++)
            pop_head($sformatf("fullpop_pop%0d", b), 8'h12 + 8'(b));

        // Reset during data bit 4.
        uart_rxd = 1'b0;
        wait_cycles(CPB * 5 + 50);
        reset = 1'b1;
        wait_cycles(2);
        uart_rxd = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(5);
        chk("midrst_count", 32'(rx_count), 32'd0);
        chk("midrst_ferr", 32'(rx_frame_err), 32'd0);
        send_byte(8'h7E, 0, 1'b0);
        chk("midrst_7e_count", 32'(rx_count), 32'd1);
        pop_head("midrst_7e_data", 8'h7E);

        // Line held low across reset release is not a start bit.
        uart_rxd = 1'b0;
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1200);
        chk("lowrst_nopush", 32'(rx_valid), 32'd0);
        chk("lowrst_noferr", 32'(rx_frame_err), 32'd0);
        uart_rxd = 1'b1;
        wait_cycles(10);
        send_byte(8'hE1, 0, 1'b0);
        pop_head("lowrst_next_data", 8'hE1);

`ifdef UART_RX_PARITY_EN
        send_byte(8'h7E, 0, 1'b1);
        chk("par_err", 32'(rx_parity_err), 32'd1);
        chk("par_nopush", 32'(rx_count), 32'd0);
        pulse_clear();
        chk("par_cleared", 32'(rx_parity_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
